// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the mux-tree scan sequencer.
package mux_scan_pkg;
    localparam int NCH      = 8;
    localparam int IDX_W    = 3;
    localparam int HOLD_MAX = 16;
    // Wide enough to hold HOLD_MAX-1, the largest terminal count.
    localparam int TMR_W    = $clog2(HOLD_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mux_scan_ctrl_step_timer.sv
// Modulo-HOLD step counter; tc marks the last cycle of each select step.
module step_timer
    import mux_scan_pkg::*;
#(
    parameter int HOLD = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(HOLD - 1);

    logic [TMR_W-1:0] cnt;

    assign tc = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + TMR_W'(1);
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Drives the l2mux data/select inputs, walks index 0..7 and loops y8 back
// into a captured word with a one-cycle valid pulse.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int HOLD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] din,
    output logic       a1,
    output logic       a2,
    output logic       b1,
    output logic       b2,
    output logic       c1,
    output logic       c2,
    output logic       d1,
    output logic       d2,
    output logic       sabcd,
    output logic       sxy,
    output logic       sz,
    input  logic       y8,
    output logic       busy,
    output logic [7:0] rdata,
    output logic       valid
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [NCH-1:0]   data_q;
    logic [NCH-1:0]   cap_q;
    logic [NCH-1:0]   rdata_q;
    logic             valid_q;

    logic in_scan, accept, step, last_step, clr_tmr, tc;

    assign in_scan   = (state_q == SCAN);
    assign accept    = (state_q == IDLE) && start && !abort;
    // Abort outranks a coincident capture, so a step needs abort low.
    assign step      = in_scan && !abort && tc;
    assign last_step = step && (idx_q == IDX_W'(NCH - 1));
    assign clr_tmr   = !in_scan || abort;

    step_timer #(
        .HOLD(HOLD)
    ) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(clr_tmr),
        .en (in_scan),
        .tc (tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SCAN;
            SCAN: begin
                if (abort)          state_d = IDLE;
                else if (last_step) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= last_step;
            if (accept) begin
                data_q <= din;
                idx_q  <= '0;
                cap_q  <= '0;
            end else if (in_scan && abort) begin
                idx_q <= '0;
            end else if (step) begin
                cap_q[idx_q] <= y8;
                idx_q        <= idx_q + IDX_W'(1);
                // Index 7 is the MSB; merge the live sample with the earlier bits.
                if (last_step) rdata_q <= {y8, cap_q[NCH-2:0]};
            end
        end
    end

    assign {d2, d1, c2, c1, b2, b1, a2, a1} = data_q;
    assign {sz, sxy, sabcd} = idx_q;
    assign busy  = (state_q != IDLE);
    assign rdata = rdata_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl with a behavioural l2mux loopback.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, abort1, start3, abort3;
    logic [7:0] din1, din3;
    logic [7:0] w1, w3;
    logic [2:0] sel1, sel3;
    logic       y8_1, y8_3, busy1, busy3, v1, v3;
    logic [7:0] rd1, rd3;
    logic [20:0] out1, out3;

    int nvec = 0;
    int nerr = 0;
    int vcnt1 = 0;
    logic [7:0] exp1[$];
    logic [7:0] exp3[$];
    logic [7:0] last1 = 8'h00;

    always #5 clk = ~clk;

    // Behavioural mux tree: index 0 selects a1 ... index 7 selects d2.
    assign y8_1 = w1[sel1];
    assign y8_3 = w3[sel3];
    assign out1 = {w1, sel1, busy1, rd1, v1};
    assign out3 = {w3, sel3, busy3, rd3, v3};

    always @(negedge clk) if (v1) vcnt1 <= vcnt1 + 1;

    mux_scan_ctrl #(.HOLD(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .din(din1),
        .a1(w1[0]), .a2(w1[1]), .b1(w1[2]), .b2(w1[3]),
        .c1(w1[4]), .c2(w1[5]), .d1(w1[6]), .d2(w1[7]),
        .sabcd(sel1[0]), .sxy(sel1[1]), .sz(sel1[2]), .y8(y8_1),
        .busy(busy1), .rdata(rd1), .valid(v1)
    );

    mux_scan_ctrl #(.HOLD(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3), .din(din3),
        .a1(w3[0]), .a2(w3[1]), .b1(w3[2]), .b2(w3[3]),
        .c1(w3[4]), .c2(w3[5]), .d1(w3[6]), .d2(w3[7]),
        .sabcd(sel3[0]), .sxy(sel3[1]), .sz(sel3[2]), .y8(y8_3),
        .busy(busy3), .rdata(rd3), .valid(v3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid1(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (v1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        nvec++;
        if (out1 !== 21'd0) begin
            nerr++;
            $display("FAIL reset_outputs_h1: got %h expected 0", out1);
        end
        nvec++;
        if (out3 !== 21'd0) begin
            nerr++;
            $display("FAIL reset_outputs_h3: got %h expected 0", out3);
        end
        rst = 1'b0;
        tick();
        nvec++;
        if (out1 !== 21'd0) begin
            nerr++;
            $display("FAIL idle_after_reset: got %h expected 0", out1);
        end
    endtask

    task automatic test_basic;
        int busy_n = 0;
        int valid_n = -1;
        logic [7:0] e;
        din1 = 8'hA5;
        start1 = 1'b1;
        exp1.push_back(8'hA5);
        tick();
        start1 = 1'b0;
        nvec++;
        if (w1 !== 8'hA5 || sel1 !== 3'd0) begin
            nerr++;
            $display("FAIL basic_launch: got data %h sel %0d expected a5 sel 0", w1, sel1);
        end
        for (int n = 0; n < 16; n++) begin
            if (busy1) busy_n++;
            if (v1) begin
                if (valid_n < 0) valid_n = n;
                nvec++;
                if (exp1.size() == 0) begin
                    nerr++;
                    $display("FAIL basic_extra_valid: got valid at %0d expected none", n);
                end else begin
                    e = exp1.pop_front();
                    if (rd1 !== e) begin
                        nerr++;
                        $display("FAIL basic_rdata: got %h expected %h", rd1, e);
                    end
                    last1 = e;
                end
            end
            tick();
        end
        nvec++;
        if (valid_n != 8) begin
            nerr++;
            $display("FAIL basic_valid_cycle: got %0d expected 8", valid_n);
        end
        nvec++;
        if (busy_n != 9) begin
            nerr++;
            $display("FAIL basic_busy_len: got %0d expected 9", busy_n);
        end
    endtask

    task automatic test_select;
        int busy_n = 0;
        logic [7:0] e;
        din3 = 8'h3C;
        start3 = 1'b1;
        exp3.push_back(8'h3C);
        tick();
        start3 = 1'b0;
        for (int n = 0; n < 25; n++) begin
            if (busy3) busy_n++;
            if (n < 24) begin
                nvec++;
                if (sel3 !== 3'(n / 3) || v3 !== 1'b0) begin
                    nerr++;
                    $display("FAIL select_step%0d: got sel %0d valid %b expected sel %0d valid 0",
                             n, sel3, v3, n / 3);
                end
            end else begin
                e = exp3.pop_front();
                nvec++;
                if (v3 !== 1'b1 || rd3 !== e) begin
                    nerr++;
                    $display("FAIL select_rdata: got valid %b rdata %h expected 1 %h", v3, rd3, e);
                end
            end
            tick();
        end
        nvec++;
        if (busy_n != 25 || busy3 !== 1'b0 || v3 !== 1'b0) begin
            nerr++;
            $display("FAIL select_busy: got len %0d busy %b valid %b expected 25 0 0",
                     busy_n, busy3, v3);
        end
    endtask

    task automatic test_busy_start;
        int vb = vcnt1;
        bit ok;
        logic [7:0] e;
        din1 = 8'h12;
        start1 = 1'b1;
        exp1.push_back(8'h12);
        tick();
        start1 = 1'b0;
        tick();
        tick();
        din1 = 8'hFF;
        start1 = 1'b1;
        tick();
        tick();
        start1 = 1'b0;
        din1 = 8'h00;
        nvec++;
        if (w1 !== 8'h12) begin
            nerr++;
            $display("FAIL busy_start_data: got %h expected 12", w1);
        end
        wait_valid1(ok);
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL busy_start_timeout: got no valid expected valid");
        end else begin
            e = exp1.pop_front();
            if (rd1 !== e) begin
                nerr++;
                $display("FAIL busy_start_rdata: got %h expected %h", rd1, e);
            end
            last1 = e;
        end
        repeat (15) tick();
        nvec++;
        if (vcnt1 != vb + 1 || busy1 !== 1'b0) begin
            nerr++;
            $display("FAIL busy_start_extra: got %0d valids busy %b expected 1 busy 0",
                     vcnt1 - vb, busy1);
        end
    endtask

    task automatic test_abort;
        int vb = vcnt1;
        bit ok;
        logic [7:0] e;
        din1 = 8'h77;
        start1 = 1'b1;
        abort1 = 1'b1;
        tick();
        start1 = 1'b0;
        abort1 = 1'b0;
        nvec++;
        if (busy1 !== 1'b0 || w1 !== 8'h12) begin
            nerr++;
            $display("FAIL start_with_abort: got busy %b data %h expected 0 12", busy1, w1);
        end
        din1 = 8'hF0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (4) tick();
        nvec++;
        if (sel1 !== 3'd4) begin
            nerr++;
            $display("FAIL abort_pre_index: got %0d expected 4", sel1);
        end
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        nvec++;
        if (busy1 !== 1'b0 || sel1 !== 3'd0 || rd1 !== last1 || w1 !== 8'hF0) begin
            nerr++;
            $display("FAIL abort_state: got busy %b sel %0d rdata %h data %h expected 0 0 %h f0",
                     busy1, sel1, rd1, w1, last1);
        end
        repeat (12) tick();
        nvec++;
        if (vcnt1 != vb) begin
            nerr++;
            $display("FAIL abort_no_valid: got %0d valids expected 0", vcnt1 - vb);
        end
        din1 = 8'h0F;
        start1 = 1'b1;
        exp1.push_back(8'h0F);
        tick();
        start1 = 1'b0;
        wait_valid1(ok);
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL abort_restart_timeout: got no valid expected valid");
        end else begin
            e = exp1.pop_front();
            if (rd1 !== e) begin
                nerr++;
                $display("FAIL abort_restart_rdata: got %h expected %h", rd1, e);
            end
            last1 = e;
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_midscan;
        int vb = vcnt1;
        bit ok;
        logic [7:0] e;
        din1 = 8'hC3;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (5) tick();
        nvec++;
        if (sel1 !== 3'd5) begin
            nerr++;
            $display("FAIL rst_pre_index: got %0d expected 5", sel1);
        end
        #2;
        rst = 1'b1;
        #1;
        nvec++;
        if (out1 !== 21'd0) begin
            nerr++;
            $display("FAIL rst_async_outputs: got %h expected 0", out1);
        end
        tick();
        tick();
        rst = 1'b0;
        repeat (12) tick();
        nvec++;
        if (vcnt1 != vb || out1 !== 21'd0) begin
            nerr++;
            $display("FAIL rst_no_valid: got %0d valids outputs %h expected 0 0",
                     vcnt1 - vb, out1);
        end
        din1 = 8'h81;
        start1 = 1'b1;
        exp1.push_back(8'h81);
        tick();
        start1 = 1'b0;
        wait_valid1(ok);
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL rst_restart_timeout: got no valid expected valid");
        end else begin
            e = exp1.pop_front();
            if (rd1 !== e) begin
                nerr++;
                $display("FAIL rst_restart_rdata: got %h expected %h", rd1, e);
            end
            last1 = e;
        end
        repeat (3) tick();
    endtask

    task automatic test_back_to_back;
        int prev = -1;
        int cnt = 0;
        logic [7:0] e;
        din1 = 8'h5A;
        start1 = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (n % 10 == 0) exp1.push_back(8'h5A);
            tick();
            if (v1) begin
                nvec++;
                if (exp1.size() == 0) begin
                    nerr++;
                    $display("FAIL b2b_extra_valid: got valid at %0d expected none", n);
                end else begin
                    e = exp1.pop_front();
                    if (rd1 !== e) begin
                        nerr++;
                        $display("FAIL b2b_rdata: got %h expected %h", rd1, e);
                    end
                end
                nvec++;
                if ((prev < 0 && n != 8) || (prev >= 0 && n - prev != 10)) begin
                    nerr++;
                    $display("FAIL b2b_spacing: got valid at %0d after %0d expected period 10",
                             n, prev);
                end
                prev = n;
                cnt++;
            end
        end
        start1 = 1'b0;
        nvec++;
        if (cnt != 4 || exp1.size() != 0) begin
            nerr++;
            $display("FAIL b2b_count: got %0d valids %0d pending expected 4 0",
                     cnt, exp1.size());
        end
        repeat (12) tick();
    endtask

    initial begin
        rst = 1'b1;
        start1 = 1'b0;
        abort1 = 1'b0;
        start3 = 1'b0;
        abort3 = 1'b0;
        din1 = 8'h00;
        din3 = 8'h00;
        test_reset();
        test_basic();
        test_select();
        test_busy_start();
        test_abort();
        test_reset_midscan();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
